// File: rtl/fighter_motion_if.sv
// Control/status bundle between the input decoder / attack FSM, fighter_motion and the sprite renderer.
interface fighter_motion_if #(
    parameter int POS_WIDTH = 10,
    parameter int KB_WIDTH  = 5,
    parameter int AJ_W      = 1
);
    logic                        frame_tick;
    logic                        move_enable;
    logic                        move_left;
    logic                        move_right;
    logic                        jump;
    logic                        knock_valid;
    logic signed [POS_WIDTH:0]   knock_dx;
    logic [KB_WIDTH-1:0]         knock_frames;
    logic [POS_WIDTH-1:0]        opponent_x;
    logic [POS_WIDTH-1:0]        pos_x;
    logic [POS_WIDTH-1:0]        pos_y;
    logic                        facing_right;
    logic [1:0]                  state;
    logic                        move_active;
    logic                        jump_active;
    logic [AJ_W-1:0]             air_jumps_left;

    modport master (
        output frame_tick, move_enable, move_left, move_right, jump,
               knock_valid, knock_dx, knock_frames, opponent_x,
        input  pos_x, pos_y, facing_right, state, move_active, jump_active,
               air_jumps_left
    );

    modport slave (
        input  frame_tick, move_enable, move_left, move_right, jump,
               knock_valid, knock_dx, knock_frames, opponent_x,
        output pos_x, pos_y, facing_right, state, move_active, jump_active,
               air_jumps_left
    );
endinterface

// File: rtl/fighter_motion.sv
// Per-player motion controller: walking, gravity jumps with air jumps, timed knockback,
// wall clamping and an opponent push-box. State advances only on enabled frame ticks.
module fighter_motion #(
    parameter int POS_WIDTH     = 10,
    parameter int GROUND_Y      = 300,
    parameter int SPAWN_X       = 100,
    parameter int MIN_X         = 40,
    parameter int MAX_X         = 600,
    parameter int WALK_SPEED    = 3,
    parameter int JUMP_VEL      = 8,
    parameter int GRAVITY_DIV   = 1,
    parameter int MAX_AIR_JUMPS = 1,
    parameter int PUSH_DIST     = 32,
    parameter int KB_WIDTH      = 5,
    parameter int PLAYER_ID     = 1
) (
    input logic             clk,
    input logic             reset,
    fighter_motion_if.slave bus
);
    localparam int AJ_W = (MAX_AIR_JUMPS > 0) ? $clog2(MAX_AIR_JUMPS + 1) : 1;
    localparam int XW   = POS_WIDTH + 2;
    localparam int GW   = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;

    typedef enum logic [1:0] {GROUND = 2'd0, AIR = 2'd1, KNOCK = 2'd2} state_t;
    typedef logic signed [XW-1:0] sx_t;

    state_t                    st_q, st_n;
    logic [POS_WIDTH-1:0]      x_q, x_n, y_q, y_n;
    logic                      face_q, face_n;
    sx_t                       vel_q, vel_n, drift_q, drift_n;
    logic [GW-1:0]             gcnt_q, gcnt_n;
    logic [KB_WIDTH-1:0]       kcnt_q, kcnt_n;
    logic signed [POS_WIDTH:0] kdx_q, kdx_n;
    logic                      kstop_q, kstop_n;
    logic [AJ_W-1:0]           aj_q, aj_n;
    logic                      jprev_q, mact_q, mact_n;

    logic          upd, jrise, walk, vert, clamped, land, push_block, airborne;
    sx_t           lock, vel_use, x_delta, x_raw, x_cand, y_raw, vel_grav, opp_s, d_new, d_old;
    logic [GW-1:0] gcnt_use, gcnt_grav;

    function automatic sx_t absd(sx_t v);
        return v[XW-1] ? -v : v;
    endfunction

    always_comb begin
        upd      = bus.frame_tick && bus.move_enable;
        jrise    = bus.jump && !jprev_q;
        walk     = bus.move_left ^ bus.move_right;
        airborne = (st_q == AIR) || (y_q != POS_WIDTH'(GROUND_Y));
        if (bus.move_right && !bus.move_left)      lock = sx_t'(WALK_SPEED);
        else if (bus.move_left && !bus.move_right) lock = -sx_t'(WALK_SPEED);
        else                                       lock = '0;

        // Pick this tick's motion source, then run one shared X/Y datapath.
        vel_use  = vel_q;
        gcnt_use = gcnt_q;
        x_delta  = '0;
        vert     = 1'b0;
        case (st_q)
            GROUND: begin
                x_delta = lock;
                if (jrise) begin
                    vel_use  = sx_t'(JUMP_VEL);
                    gcnt_use = '0;
                    vert     = 1'b1;
                end
            end
            AIR: begin
                vert    = 1'b1;
                x_delta = drift_q;
                if (jrise && aj_q != '0) begin
                    vel_use  = sx_t'(JUMP_VEL);
                    gcnt_use = '0;
                    x_delta  = lock;
                end
            end
            default: begin
                vert    = (y_q != POS_WIDTH'(GROUND_Y));
                x_delta = kstop_q ? '0 : sx_t'(kdx_q);
            end
        endcase

        x_raw   = sx_t'({2'b00, x_q}) + x_delta;
        x_cand  = x_raw;
        clamped = 1'b0;
        if (x_raw < sx_t'(MIN_X)) begin
            x_cand  = sx_t'(MIN_X);
            clamped = 1'b1;
        end else if (x_raw > sx_t'(MAX_X)) begin
            x_cand  = sx_t'(MAX_X);
            clamped = 1'b1;
        end
        opp_s      = sx_t'({2'b00, bus.opponent_x});
        d_new      = absd(x_cand - opp_s);
        d_old      = absd(sx_t'({2'b00, x_q}) - opp_s);
        push_block = (d_new < sx_t'(PUSH_DIST)) && (d_new < d_old);

        y_raw = sx_t'({2'b00, y_q}) - vel_use;
        land  = vert && (y_raw >= sx_t'(GROUND_Y)) && (vel_use[XW-1] || vel_use == '0);
        if (gcnt_use == GW'(GRAVITY_DIV - 1)) begin
            gcnt_grav = '0;
            vel_grav  = (vel_use <= -sx_t'(JUMP_VEL)) ? vel_use : vel_use - sx_t'(1);
        end else begin
            gcnt_grav = gcnt_use + GW'(1);
            vel_grav  = vel_use;
        end

        st_n    = st_q;
        x_n     = x_q;
        y_n     = y_q;
        face_n  = face_q;
        vel_n   = vel_q;
        drift_n = drift_q;
        gcnt_n  = gcnt_q;
        kcnt_n  = kcnt_q;
        kdx_n   = kdx_q;
        kstop_n = kstop_q;
        aj_n    = aj_q;
        mact_n  = mact_q;

        if (upd) begin
            if (bus.knock_valid) begin
                st_n    = KNOCK;
                kcnt_n  = (bus.knock_frames == '0) ? KB_WIDTH'(1) : bus.knock_frames;
                kdx_n   = bus.knock_dx;
                kstop_n = 1'b0;
                if (airborne) begin
                    vel_n  = '0;
                    gcnt_n = '0;
                end
            end else begin
                if (st_q == GROUND && !jrise) begin
                    if (walk && !push_block) x_n = x_cand[POS_WIDTH-1:0];
                end else begin
                    x_n = x_cand[POS_WIDTH-1:0];
                    if (land) begin
                        y_n    = POS_WIDTH'(GROUND_Y);
                        vel_n  = '0;
                        gcnt_n = '0;
                    end else if (vert) begin
                        y_n    = y_raw[POS_WIDTH-1:0];
                        vel_n  = vel_grav;
                        gcnt_n = gcnt_grav;
                    end
                end
                case (st_q)
                    GROUND: begin
                        if (jrise) begin
                            st_n    = AIR;
                            drift_n = clamped ? '0 : lock;
                        end
                        if (x_n < bus.opponent_x)      face_n = 1'b1;
                        else if (x_n > bus.opponent_x) face_n = 1'b0;
                    end
                    AIR: begin
                        if (jrise && aj_q != '0) begin
                            aj_n    = aj_q - AJ_W'(1);
                            drift_n = lock;
                        end
                        if (clamped) drift_n = '0;
                        if (land) begin
                            st_n    = GROUND;
                            aj_n    = AJ_W'(MAX_AIR_JUMPS);
                            drift_n = '0;
                        end
                    end
                    default: begin
                        if (clamped) kstop_n = 1'b1;
                        kcnt_n = kcnt_q - KB_WIDTH'(1);
                        if (kcnt_q == KB_WIDTH'(1)) begin
                            drift_n = '0;
                            if (y_n == POS_WIDTH'(GROUND_Y)) begin
                                st_n = GROUND;
                                aj_n = AJ_W'(MAX_AIR_JUMPS);
                            end else begin
                                st_n = AIR;
                                aj_n = '0;
                            end
                        end
                    end
                endcase
            end
            mact_n = (x_n != x_q) || (y_n != y_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= GROUND;
            x_q     <= POS_WIDTH'(SPAWN_X);
            y_q     <= POS_WIDTH'(GROUND_Y);
            face_q  <= (PLAYER_ID == 1);
            vel_q   <= '0;
            drift_q <= '0;
            gcnt_q  <= '0;
            kcnt_q  <= '0;
            kdx_q   <= '0;
            kstop_q <= 1'b0;
            aj_q    <= AJ_W'(MAX_AIR_JUMPS);
            jprev_q <= 1'b0;
            mact_q  <= 1'b0;
        end else begin
            st_q    <= st_n;
            x_q     <= x_n;
            y_q     <= y_n;
            face_q  <= face_n;
            vel_q   <= vel_n;
            drift_q <= drift_n;
            gcnt_q  <= gcnt_n;
            kcnt_q  <= kcnt_n;
            kdx_q   <= kdx_n;
            kstop_q <= kstop_n;
            aj_q    <= aj_n;
            mact_q  <= mact_n;
            if (upd) jprev_q <= bus.jump;
        end
    end

    assign bus.pos_x          = x_q;
    assign bus.pos_y          = y_q;
    assign bus.facing_right   = face_q;
    assign bus.state          = st_q;
    assign bus.move_active    = mact_q;
    assign bus.jump_active    = (st_q != GROUND) || (y_q != POS_WIDTH'(GROUND_Y));
    assign bus.air_jumps_left = aj_q;
endmodule

// File: tb/tb_fighter_motion.sv
// Bench for fighter_motion: fixed jump-arc table, directed corner sequences and
// randomized ticks, all checked against a plain-integer behavioural model.
module tb_fighter_motion;
    localparam int PW = 10, GY = 300, SPAWN = 100, MINX = 40, MAXX = 600, WS = 3;
    localparam int JV = 8, GDIV = 1, MAXAJ = 1, PD = 32, KBW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fighter_motion_if #(.POS_WIDTH(PW), .KB_WIDTH(KBW), .AJ_W(1)) bus ();

    fighter_motion #(
        .POS_WIDTH(PW), .GROUND_Y(GY), .SPAWN_X(SPAWN), .MIN_X(MINX), .MAX_X(MAXX),
        .WALK_SPEED(WS), .JUMP_VEL(JV), .GRAVITY_DIV(GDIV), .MAX_AIR_JUMPS(MAXAJ),
        .PUSH_DIST(PD), .KB_WIDTH(KBW), .PLAYER_ID(1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_chk = 0, n_err = 0;

    // Reference model state (state: 0 ground, 1 air, 2 knock)
    int m_x, m_y, m_face, m_st, m_vel, m_drift, m_g, m_k, m_kdx, m_kstop, m_aj, m_jprev, m_mact;

    typedef struct { bit j; int ey; int est; } arc_t;
    arc_t arc[17];

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampx(int v);
        if (v < MINX) return MINX;
        if (v > MAXX) return MAXX;
        return v;
    endfunction

    task automatic model_reset();
        m_x = SPAWN; m_y = GY; m_face = 1; m_st = 0; m_vel = 0; m_drift = 0; m_g = 0;
        m_k = 0; m_kdx = 0; m_kstop = 0; m_aj = MAXAJ; m_jprev = 0; m_mact = 0;
    endtask

    // One tick of ballistic motion; reports whether the player touched the floor.
    task automatic fall(output bit landed);
        int ny;
        ny = m_y - m_vel;
        landed = (ny >= GY) && (m_vel <= 0);
        m_g++;
        if (m_g >= GDIV) begin
            m_g = 0;
            if (m_vel > -JV) m_vel--;
        end
        if (landed) begin
            m_y = GY; m_vel = 0; m_g = 0;
        end else begin
            m_y = ny;
        end
    endtask

    task automatic model_step(input bit l, r, j, kv, input int kdx, kf, opp);
        bit rise, landed, was_ground;
        int ox, oy, lock, c;
        rise = j && !m_jprev;
        m_jprev = j;
        ox = m_x; oy = m_y;
        lock = (r && !l) ? WS : ((l && !r) ? -WS : 0);
        if (kv) begin
            if (m_st == 1 || m_y != GY) begin m_vel = 0; m_g = 0; end
            m_st = 2; m_k = (kf == 0) ? 1 : kf; m_kdx = kdx; m_kstop = 0;
        end else if (m_st == 2) begin
            if (!m_kstop) begin
                c = m_x + m_kdx;
                if (clampx(c) != c) m_kstop = 1;
                m_x = clampx(c);
            end
            if (m_y != GY) fall(landed);
            m_k--;
            if (m_k == 0) begin
                m_drift = 0;
                if (m_y == GY) begin m_st = 0; m_aj = MAXAJ; end
                else begin m_st = 1; m_aj = 0; end
            end
        end else begin
            was_ground = (m_st == 0);
            if (m_st == 0 && rise) begin
                m_st = 1; m_vel = JV; m_g = 0; m_drift = lock;
            end else if (m_st == 1 && rise && m_aj > 0) begin
                m_aj--; m_vel = JV; m_g = 0; m_drift = lock;
            end
            if (m_st == 1) begin
                c = m_x + m_drift;
                if (clampx(c) != c) m_drift = 0;
                m_x = clampx(c);
                fall(landed);
                if (landed) begin m_st = 0; m_aj = MAXAJ; m_drift = 0; end
            end else if (l != r) begin
                c = clampx(m_x + lock);
                if (!(iabs(c - opp) < PD && iabs(c - opp) < iabs(m_x - opp))) m_x = c;
            end
            if (was_ground) begin
                if (m_x < opp) m_face = 1;
                else if (m_x > opp) m_face = 0;
            end
        end
        m_mact = (m_x != ox || m_y != oy) ? 1 : 0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, " pos_x"}, int'(bus.pos_x), m_x);
        chk({tag, " pos_y"}, int'(bus.pos_y), m_y);
        chk({tag, " state"}, int'(bus.state), m_st);
        chk({tag, " facing"}, int'(bus.facing_right), m_face);
        chk({tag, " air_jumps"}, int'(bus.air_jumps_left), m_aj);
        chk({tag, " move_active"}, int'(bus.move_active), m_mact);
        chk({tag, " jump_active"}, int'(bus.jump_active), (m_st != 0 || m_y != GY) ? 1 : 0);
    endtask

    task automatic idle();
        bus.frame_tick = 0; bus.move_enable = 1; bus.move_left = 0; bus.move_right = 0;
        bus.jump = 0; bus.knock_valid = 0; bus.knock_dx = '0; bus.knock_frames = '0;
    endtask

    task automatic cyc(input bit ft, en, l, r, j, kv, input int kdx, kf, opp, input string tag);
        bus.frame_tick = ft; bus.move_enable = en; bus.move_left = l; bus.move_right = r;
        bus.jump = j; bus.knock_valid = kv; bus.knock_dx = (PW + 1)'(kdx);
        bus.knock_frames = KBW'(kf); bus.opponent_x = PW'(opp);
        @(posedge clk);
        #1;
        if (ft && en) model_step(l, r, j, kv, kdx, kf, opp);
        chk_all(tag);
    endtask

    task automatic run_to_ground(input int opp, input string tag);
        int n;
        n = 0;
        while (m_st != 0 && n < 60) begin
            cyc(1, 1, 0, 0, 0, 0, 0, 0, opp, tag);
            n++;
        end
        chk({tag, " landed"}, int'(bus.state), 0);
        chk({tag, " aj_restored"}, int'(bus.air_jumps_left), MAXAJ);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ys[17] = '{292, 285, 279, 274, 270, 267, 265, 264, 264, 265, 267, 270, 274, 279, 285, 292, 300};
        int opp;
        bit ft, en, l, r, j, kv;
        int kdx, kf;

        for (int i = 0; i < 17; i++) begin
            arc[i].j   = (i == 0);
            arc[i].ey  = ys[i];
            arc[i].est = (i == 16) ? 0 : 1;
        end

        idle();
        bus.opponent_x = PW'(400);
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk_all("reset");

        // Single jump arc from the ground
        for (int i = 0; i < 17; i++) begin
            cyc(1, 1, 0, 0, arc[i].j, 0, 0, 0, 400, "arc");
            chk("arc y", int'(bus.pos_y), arc[i].ey);
            chk("arc state", int'(bus.state), arc[i].est);
            chk("arc x", int'(bus.pos_x), SPAWN);
        end

        // Walk into the right wall, then knock back to 590
        for (int i = 0; i < 170; i++) cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, "walk");
        chk("wall clamp x", int'(bus.pos_x), MAXX);
        chk("facing left", int'(bus.facing_right), 0);
        cyc(1, 1, 0, 0, 0, 1, -10, 1, 0, "kb_set");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, "kb_set");
        chk("kb set x", int'(bus.pos_x), 590);
        chk("kb set state", int'(bus.state), 0);

        // Drifting jump clamps at the wall and stays there
        for (int t = 1; t <= 17; t++) begin
            cyc(1, 1, 0, 1, (t == 1), 0, 0, 0, 0, "drift");
            if (t == 4) chk("drift clamp x", int'(bus.pos_x), 600);
        end
        chk("drift land state", int'(bus.state), 0);
        chk("drift land x", int'(bus.pos_x), 600);

        // Double jump, third edge ignored
        for (int t = 1; t <= 7; t++) begin
            cyc(1, 1, 0, 0, (t == 1 || t == 5 || t == 7), 0, 0, 0, 0, "dbl");
            if (t == 5) chk("dbl aj after air jump", int'(bus.air_jumps_left), 0);
        end
        chk("third jump ignored aj", int'(bus.air_jumps_left), 0);
        chk("third jump state", int'(bus.state), 1);
        run_to_ground(0, "dbl");

        // Push-box against an opponent at 235
        cyc(1, 1, 0, 0, 0, 1, -100, 4, 0, "kb_200");
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, "kb_200");
        chk("kb 200 x", int'(bus.pos_x), 200);
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 235, "push");
        chk("push first step", int'(bus.pos_x), 203);
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 235, "push");
        chk("push blocked", int'(bus.pos_x), 203);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 235, "push");
        chk("push walk away", int'(bus.pos_x), 200);
        chk("push facing", int'(bus.facing_right), 1);

        // Knockback while airborne
        for (int t = 1; t <= 3; t++) cyc(1, 1, 0, 0, (t == 1), 0, 0, 0, 235, "kair");
        cyc(1, 1, 0, 0, 0, 1, -4, 3, 235, "kair");
        chk("kair entry state", int'(bus.state), 2);
        chk("kair entry x", int'(bus.pos_x), 200);
        for (int t = 1; t <= 3; t++) cyc(1, 1, 1, 0, 1, 0, 0, 0, 235, "kair");
        chk("kair x", int'(bus.pos_x), 188);
        chk("kair exit state", int'(bus.state), 1);
        chk("kair exit aj", int'(bus.air_jumps_left), 0);
        run_to_ground(235, "kair");

        // Asynchronous reset in the middle of a knockback
        cyc(1, 1, 0, 0, 0, 1, 5, 20, 300, "krst");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 300, "krst");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 300, "krst");
        idle();
        #2 reset = 1;
        #1;
        chk("rst x", int'(bus.pos_x), SPAWN);
        chk("rst y", int'(bus.pos_y), GY);
        chk("rst state", int'(bus.state), 0);
        chk("rst facing", int'(bus.facing_right), 1);
        model_reset();
        @(posedge clk);
        #1;
        chk_all("rst");
        reset = 0;

        // Freeze with move_enable low; held jump is not re-detected afterwards
        cyc(1, 1, 0, 0, 1, 0, 0, 0, 400, "frz");
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 1, 0, 1, 1, 7, 3, 400, "frz");
            chk("frz y", int'(bus.pos_y), 292);
            chk("frz x", int'(bus.pos_x), SPAWN);
        end
        cyc(1, 1, 0, 0, 1, 0, 0, 0, 400, "frz");
        chk("frz held jump aj", int'(bus.air_jumps_left), 1);
        chk("frz resume y", int'(bus.pos_y), 285);
        run_to_ground(400, "frz");

        // Randomized ticks against the model
        opp = 300;
        for (int i = 0; i < 700; i++) begin
            ft  = ($urandom_range(0, 7) != 0);
            en  = ($urandom_range(0, 9) != 0);
            l   = $urandom_range(0, 1) != 0;
            r   = $urandom_range(0, 1) != 0;
            j   = ($urandom_range(0, 2) == 0);
            kv  = ($urandom_range(0, 24) == 0);
            kdx = int'($urandom_range(0, 24)) - 12;
            kf  = int'($urandom_range(0, 6));
            if (i % 40 == 0) begin
                opp = m_x + int'($urandom_range(0, 80)) - 40;
                if (opp < 0) opp = 0;
                if (opp > 1023) opp = 1023;
            end
            cyc(ft, en, l, r, j, kv, kdx, kf, opp, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
